// File: rtl/lcd_3wire_pkg.sv
// Shared types and frame layout for the LCD 3-wire write arbiter.
// Frame on the wire, MSB first: 6b register address, 2b control, 8b data.
package lcd_3wire_pkg;

    localparam int FRAME_W = 16;
    localparam int ADDR_W  = 6;
    localparam int CTL_W   = 2;
    localparam int DATA_W  = 8;

    localparam logic [CTL_W-1:0] CTL_WRITE = 2'b01;

    typedef logic [FRAME_W-1:0] frame_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GAP,
        S_ISSUE,
        S_WAIT
    } arb_state_t;

    typedef struct packed {
        logic   req;
        frame_t data;
    } wr_req_t;

    function automatic logic [ADDR_W-1:0] frame_addr(input frame_t f);
        return f[FRAME_W-1 -: ADDR_W];
    endfunction

    function automatic logic [CTL_W-1:0] frame_ctl(input frame_t f);
        return f[DATA_W +: CTL_W];
    endfunction

    function automatic logic [DATA_W-1:0] frame_data(input frame_t f);
        return f[DATA_W-1:0];
    endfunction

    function automatic logic frame_is_write(input frame_t f);
        return frame_ctl(f) == CTL_WRITE;
    endfunction

    // Counter width able to hold 0..maxv; never narrower than one bit.
    function automatic int cnt_w(input int maxv);
        return (maxv < 1) ? 1 : $clog2(maxv + 1);
    endfunction

endpackage

// File: rtl/lcd_3wire_arbiter_rr_arb2.sv
// Two-way round-robin pick. On a tie the port that did not win last time
// is chosen; last_gnt powers up as 1 so port 0 wins the first tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       take,
    output logic       vld,
    output logic       idx
);

    logic last_gnt;

    always_comb begin
        vld = |req;
        idx = (req == 2'b11) ? ~last_gnt : req[1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            last_gnt <= 1'b1;
        else if (take && vld)
            last_gnt <= idx;
    end

endmodule

// File: rtl/lcd_3wire_arbiter.sv
// Shares one LCD 3-wire serial engine between the config sequencer (port 0)
// and the runtime writer (port 1): arbitration, inter-frame gap, retry, timeout.
module lcd_3wire_arbiter
    import lcd_3wire_pkg::*;
#(
    parameter int GAP_CYC   = 2,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 1023
) (
    input  logic               iCLK,
    input  logic               iRST_n,
    input  logic               iREQ0,
    input  logic               iREQ1,
    input  logic [FRAME_W-1:0] iDATA0,
    input  logic [FRAME_W-1:0] iDATA1,
    output logic               oDONE0,
    output logic               oDONE1,
    output logic               oERR0,
    output logic               oERR1,
    output logic               oGNT,
    output logic               oBUSY_n,
    output logic [FRAME_W-1:0] oENG_DATA,
    output logic               oENG_STR,
    input  logic               iENG_RDY,
    input  logic               iENG_ACK
);

    localparam int GW = cnt_w(GAP_CYC);
    localparam int RW = cnt_w(MAX_RETRY);
    localparam int TW = cnt_w(TIMEOUT);

    arb_state_t      state;
    logic [GW-1:0]   gap;
    logic [RW-1:0]   retry;
    logic [TW-1:0]   tmo;
    logic [1:0]      done_q;
    logic [1:0]      err_q;

    wr_req_t [1:0]   rq;
    logic [1:0]      elig;
    logic            arb_vld;
    logic            arb_idx;
    logic            arb_take;
    logic            tmo_hit;
    logic            frame_fail;

    assign rq[0] = '{req: iREQ0, data: iDATA0};
    assign rq[1] = '{req: iREQ1, data: iDATA1};

    // A port still showing its done/err pulse has not yet seen the result,
    // so its level request must not start a second transaction.
    for (genvar i = 0; i < 2; i++) begin : g_elig
        assign elig[i] = rq[i].req & ~(done_q[i] | err_q[i]);
    end

    assign arb_take   = (state == S_IDLE);
    assign tmo_hit    = (tmo == TW'(TIMEOUT));
    // RDY takes priority over a timeout landing on the same cycle.
    assign frame_fail = iENG_RDY ? ~iENG_ACK : tmo_hit;

    rr_arb2 u_arb (
        .clk   (iCLK),
        .rst_n (iRST_n),
        .req   (elig),
        .take  (arb_take),
        .vld   (arb_vld),
        .idx   (arb_idx)
    );

    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            state     <= S_IDLE;
            oENG_STR  <= 1'b0;
            oENG_DATA <= '0;
            done_q    <= '0;
            err_q     <= '0;
            oGNT      <= 1'b0;
            oBUSY_n   <= 1'b1;
            gap       <= '0;
            retry     <= '0;
            tmo       <= '0;
        end else begin
            done_q <= '0;
            err_q  <= '0;
            unique case (state)
                S_IDLE: begin
                    if (arb_vld) begin
                        oENG_DATA <= rq[arb_idx].data;
                        oGNT      <= arb_idx;
                        retry     <= '0;
                        gap       <= GW'(GAP_CYC);
                        oBUSY_n   <= 1'b0;
                        state     <= S_GAP;
                    end
                end
                S_GAP: begin
                    gap <= gap - GW'(1);
                    if (gap == GW'(1))
                        state <= S_ISSUE;
                end
                S_ISSUE: begin
                    oENG_STR <= 1'b1;
                    tmo      <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (iENG_RDY && iENG_ACK) begin
                        oENG_STR     <= 1'b0;
                        done_q[oGNT] <= 1'b1;
                        oBUSY_n      <= 1'b1;
                        state        <= S_IDLE;
                    end else if (frame_fail) begin
                        oENG_STR <= 1'b0;
                        if (retry < RW'(MAX_RETRY)) begin
                            // Same owner, same latched frame, fresh gap.
                            retry <= retry + RW'(1);
                            gap   <= GW'(GAP_CYC);
                            state <= S_GAP;
                        end else begin
                            err_q[oGNT] <= 1'b1;
                            oBUSY_n     <= 1'b1;
                            state       <= S_IDLE;
                        end
                    end else begin
                        tmo <= tmo + TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign oDONE0 = done_q[0];
    assign oDONE1 = done_q[1];
    assign oERR0  = err_q[0];
    assign oERR1  = err_q[1];

endmodule

// File: tb/tb_lcd_3wire_arbiter.sv
// Directed bench for lcd_3wire_arbiter: vector table of single-requester
// transactions plus hand-written tie, timeout and reset sequences.
module tb_lcd_3wire_arbiter;

    localparam int GAP_CYC = 2;

    logic        iCLK = 1'b0;
    logic        iRST_n = 1'b0;
    logic        iREQ0 = 1'b0, iREQ1 = 1'b0;
    logic [15:0] iDATA0 = '0, iDATA1 = '0;
    logic        oDONE0, oDONE1, oERR0, oERR1, oGNT, oBUSY_n, oENG_STR;
    logic [15:0] oENG_DATA;
    logic        iENG_RDY = 1'b0, iENG_ACK = 1'b0;

    always #5 iCLK = ~iCLK;

    lcd_3wire_arbiter #(.GAP_CYC(GAP_CYC), .MAX_RETRY(3), .TIMEOUT(1023)) dut (
        .iCLK(iCLK), .iRST_n(iRST_n),
        .iREQ0(iREQ0), .iREQ1(iREQ1), .iDATA0(iDATA0), .iDATA1(iDATA1),
        .oDONE0(oDONE0), .oDONE1(oDONE1), .oERR0(oERR0), .oERR1(oERR1),
        .oGNT(oGNT), .oBUSY_n(oBUSY_n), .oENG_DATA(oENG_DATA), .oENG_STR(oENG_STR),
        .iENG_RDY(iENG_RDY), .iENG_ACK(iENG_ACK)
    );

    // ---------------- monitor ----------------
    int cyc = 0, n_str = 0, n_done0 = 0, n_done1 = 0, n_err0 = 0, n_err1 = 0;
    int gap_viol = 0, low_run = 100, high_run = 0, last_high = 0;
    int last_lat = -1, grant_cyc = 0;
    bit str_prev = 1'b0, busy_prev = 1'b1, lat_pending = 1'b0;

    always @(negedge iCLK) begin
        cyc++;
        if (oDONE0) n_done0++;
        if (oDONE1) n_done1++;
        if (oERR0)  n_err0++;
        if (oERR1)  n_err1++;
        if (busy_prev && !oBUSY_n) begin
            grant_cyc   = cyc;
            lat_pending = 1'b1;
        end
        if (oENG_STR && !str_prev) begin
            n_str++;
            if (low_run < GAP_CYC) gap_viol++;
            if (lat_pending) begin
                last_lat    = cyc - grant_cyc;
                lat_pending = 1'b0;
            end
        end
        if (oENG_STR) begin
            high_run++;
            low_run = 0;
        end else begin
            if (str_prev) last_high = high_run;
            high_run = 0;
            low_run++;
        end
        str_prev  = oENG_STR;
        busy_prev = oBUSY_n;
    end

    // ---------------- checking ----------------
    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    int b_str, b_d0, b_d1, b_e0, b_e1, b_gv;

    task automatic snap();
        b_str = n_str; b_d0 = n_done0; b_d1 = n_done1;
        b_e0 = n_err0; b_e1 = n_err1; b_gv = gap_viol;
    endtask

    task automatic settle();
        repeat (2) @(negedge iCLK);
        #1;
    endtask

    task automatic set_req(input bit p, input logic v);
        if (p) iREQ1 = v; else iREQ0 = v;
    endtask

    task automatic set_data(input bit p, input logic [15:0] d);
        if (p) iDATA1 = d; else iDATA0 = d;
    endtask

    // Wait (at negedges) until STR or BUSY_n is high; timeout is a failed check.
    task automatic wait_str_or_idle(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (oENG_STR || oBUSY_n) begin
                ok = 1'b1;
                break;
            end
            @(negedge iCLK);
        end
        if (!ok) chk("wait_str_or_idle_timeout", 0, 1);
    endtask

    task automatic wait_busy(input logic lvl, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (oBUSY_n == lvl) begin
                ok = 1'b1;
                break;
            end
            @(negedge iCLK);
        end
        if (!ok) chk("wait_busy_timeout", 0, 1);
    endtask

    // Engine: wait for STR, hold it lat cycles, answer with a 1-cycle RDY.
    task automatic serve(input int lat, input logic ack, output bit ok,
                         output logic gnt, output logic [15:0] data);
        ok = 1'b0;
        gnt = 1'b0;
        data = '0;
        for (int i = 0; i < 200; i++) begin
            if (oENG_STR) begin
                ok = 1'b1;
                break;
            end
            @(negedge iCLK);
        end
        if (!ok) begin
            chk("serve_str_timeout", 0, 1);
        end else begin
            gnt  = oGNT;
            data = oENG_DATA;
            repeat (lat) @(negedge iCLK);
            iENG_RDY = 1'b1;
            iENG_ACK = ack;
            @(negedge iCLK);
            iENG_RDY = 1'b0;
            iENG_ACK = 1'b0;
        end
    endtask

    task automatic do_reset();
        iRST_n = 1'b0;
        repeat (2) @(negedge iCLK);
        iRST_n = 1'b1;
        @(negedge iCLK);
    endtask

    typedef struct {
        bit          port;
        logic [15:0] data;
        int          nacks;     // engine NACKs this many times, then ACKs
        int          lat;       // engine cycles from STR seen to RDY
        bit          drop;      // requester drops REQ right after grant
        int          exp_str;
        int          exp_done;
        int          exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input int idx, input vec_t v);
        bit ok;
        int frames, data_bad;
        string tag;
        tag = $sformatf("v%0d", idx);
        snap();
        set_data(v.port, v.data);
        set_req(v.port, 1'b1);
        @(negedge iCLK);
        wait_busy(1'b0, 20, ok);
        // Data changes after grant must not reach the engine.
        set_data(v.port, ~v.data);
        if (v.drop) set_req(v.port, 1'b0);
        frames = 0;
        data_bad = 0;
        for (int f = 0; f < 20 && ok; f++) begin
            wait_str_or_idle(3000, ok);
            if (!ok || oBUSY_n) break;
            if (oENG_DATA !== v.data) data_bad++;
            repeat (v.lat) @(negedge iCLK);
            iENG_RDY = 1'b1;
            iENG_ACK = (frames >= v.nacks);
            @(negedge iCLK);
            iENG_RDY = 1'b0;
            iENG_ACK = 1'b0;
            frames++;
        end
        set_req(v.port, 1'b0);
        settle();
        chk({tag, "_data_bad"}, data_bad, 0);
        chk({tag, "_str_cnt"}, n_str - b_str, v.exp_str);
        chk({tag, "_done_own"}, v.port ? n_done1 - b_d1 : n_done0 - b_d0, v.exp_done);
        chk({tag, "_err_own"}, v.port ? n_err1 - b_e1 : n_err0 - b_e0, v.exp_err);
        chk({tag, "_other_pulses"},
            v.port ? (n_done0 - b_d0) + (n_err0 - b_e0) : (n_done1 - b_d1) + (n_err1 - b_e1), 0);
        chk({tag, "_busy_n"}, int'(oBUSY_n), 1);
        chk({tag, "_gnt_to_str_lat"}, last_lat, GAP_CYC + 1);
        chk({tag, "_gap_viol"}, gap_viol - b_gv, 0);
    endtask

    initial begin
        bit ok;
        logic g;
        logic [15:0] d;
        logic [1:0]  exp_g [4];
        logic [15:0] exp_d [4];

        //                port  data      nack lat drop str done err
        vecs[0] = '{1'b0, 16'h4507, 0,   40, 1'b0, 1,  1,   0};
        vecs[1] = '{1'b1, 16'h1234, 3,   5,  1'b0, 4,  1,   0};
        vecs[2] = '{1'b0, 16'hA55A, 99,  3,  1'b0, 4,  0,   1};
        vecs[3] = '{1'b1, 16'h0F0F, 0,   1,  1'b1, 1,  1,   0};
        vecs[4] = '{1'b0, 16'hFFFF, 2,   0,  1'b0, 3,  1,   0};

        // Reset state, sampled while reset is held.
        repeat (3) @(negedge iCLK);
        #1;
        chk("rst_str", int'(oENG_STR), 0);
        chk("rst_data", int'(oENG_DATA), 0);
        chk("rst_busy_n", int'(oBUSY_n), 1);
        chk("rst_gnt", int'(oGNT), 0);
        chk("rst_pulses", int'({oDONE0, oDONE1, oERR0, oERR1}), 0);
        iRST_n = 1'b1;
        @(negedge iCLK);

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // Simultaneous requests held across four frames: strict alternation from 0.
        do_reset();
        snap();
        exp_g = '{2'd0, 2'd1, 2'd0, 2'd1};
        exp_d = '{16'h1111, 16'h2222, 16'h1111, 16'h2222};
        iDATA0 = 16'h1111;
        iDATA1 = 16'h2222;
        iREQ0 = 1'b1;
        iREQ1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            serve(2, 1'b1, ok, g, d);
            chk($sformatf("tie_gnt%0d", i), int'(g), int'(exp_g[i]));
            chk($sformatf("tie_data%0d", i), int'(d), int'(exp_d[i]));
        end
        iREQ0 = 1'b0;
        iREQ1 = 1'b0;
        settle();
        chk("tie_done0", n_done0 - b_d0, 2);
        chk("tie_done1", n_done1 - b_d1, 2);
        chk("tie_gap_viol", gap_viol - b_gv, 0);
        chk("tie_busy_n", int'(oBUSY_n), 1);

        // Engine never answers: four 1024-cycle STR windows, then ERR0.
        snap();
        iDATA0 = 16'h5A5A;
        iREQ0 = 1'b1;
        @(negedge iCLK);
        wait_busy(1'b0, 20, ok);
        wait_busy(1'b1, 6000, ok);
        iREQ0 = 1'b0;
        settle();
        chk("tmo_str_cnt", n_str - b_str, 4);
        chk("tmo_high_len", last_high, 1024);
        chk("tmo_err0", n_err0 - b_e0, 1);
        chk("tmo_done0", n_done0 - b_d0, 0);
        chk("tmo_busy_n", int'(oBUSY_n), 1);

        // Reset while waiting on the engine: silent abort, then re-grant.
        snap();
        iDATA0 = 16'h3C3C;
        iREQ0 = 1'b1;
        for (int i = 0; i < 50 && !oENG_STR; i++) @(negedge iCLK);
        chk("rst6_str_seen", int'(oENG_STR), 1);
        repeat (5) @(negedge iCLK);
        iRST_n = 1'b0;
        @(negedge iCLK);
        #1;
        chk("rst6_str", int'(oENG_STR), 0);
        chk("rst6_busy_n", int'(oBUSY_n), 1);
        chk("rst6_pulses", (n_done0 - b_d0) + (n_err0 - b_e0), 0);
        iRST_n = 1'b1;
        serve(3, 1'b1, ok, g, d);
        chk("rst6_regnt", int'(g), 0);
        chk("rst6_redata", int'(d), 16'h3C3C);
        iREQ0 = 1'b0;
        settle();
        chk("rst6_done0", n_done0 - b_d0, 1);
        chk("rst6_err0", n_err0 - b_e0, 0);
        chk("rst6_str_cnt", n_str - b_str, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", n_pass, n_chk);
        $fatal(1);
    end

endmodule
